// File: rtl/fetch_queue.sv
// Show-ahead instruction fetch queue between fetch and decode.
// Holds instruction, PC, PC+4 and branch-prediction bits per entry; flush empties it in one cycle.
module fetch_queue #(
   parameter int               WIDTH = 32,
   parameter int               DEPTH = 4,
   parameter logic [WIDTH-1:0] NOP   = 32'h0000_0013
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push_valid,
   output logic                         push_ready,
   input  logic [WIDTH-1:0]             inst_in,
   input  logic [WIDTH-1:0]             pc_in,
   input  logic [WIDTH-1:0]             normal_in,
   input  logic                         bp_en_in,
   input  logic                         bp_decision_in,
   input  logic                         pop_ready,
   output logic                         out_valid,
   output logic [WIDTH-1:0]             inst_out,
   output logic [WIDTH-1:0]             pc_out,
   output logic [WIDTH-1:0]             normal_out,
   output logic                         bp_en_out,
   output logic                         bp_decision_out,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = 3*WIDTH + 2;

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;
   logic [EW-1:0] head;

   // push_ready depends only on count, so a pop never opens a slot in the same cycle
   assign full       = (count == CW'(DEPTH));
   assign push_ready = !full;
   assign out_valid  = (count != '0);
   assign do_push    = push_valid && !full;
   assign do_pop     = pop_ready && out_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= {inst_in, pc_in, normal_in, bp_en_in, bp_decision_in};
   end

   // An empty queue presents a NOP bubble with all other fields cleared
   always_comb begin
      head            = mem[rd_ptr];
      inst_out        = NOP;
      pc_out          = '0;
      normal_out      = '0;
      bp_en_out       = 1'b0;
      bp_decision_out = 1'b0;
      if (out_valid) begin
         inst_out        = head[EW-1 -: WIDTH];
         pc_out          = head[2*WIDTH+1 -: WIDTH];
         normal_out      = head[WIDTH+1 -: WIDTH];
         bp_en_out       = head[1];
         bp_decision_out = head[0];
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes accepted entries into an expected queue,
// a negedge monitor compares the presented head, count and push_ready against it every cycle.
module tb_fetch_queue;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] normal;
      logic        bp_en;
      logic        bp_dec;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        push_valid;
   logic        push_ready;
   logic [31:0] inst_in;
   logic [31:0] pc_in;
   logic [31:0] normal_in;
   logic        bp_en_in;
   logic        bp_decision_in;
   logic        pop_ready;
   logic        out_valid;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic [31:0] normal_out;
   logic        bp_en_out;
   logic        bp_decision_out;
   logic [2:0]  count;

   int tests  = 0;
   int failed = 0;
   entry_t exp_q[$];

   fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP(32'h0000_0013)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .push_valid(push_valid), .push_ready(push_ready),
      .inst_in(inst_in), .pc_in(pc_in), .normal_in(normal_in),
      .bp_en_in(bp_en_in), .bp_decision_in(bp_decision_in),
      .pop_ready(pop_ready), .out_valid(out_valid),
      .inst_out(inst_out), .pc_out(pc_out), .normal_out(normal_out),
      .bp_en_out(bp_en_out), .bp_decision_out(bp_decision_out),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failed++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs, then returns 1 time unit after the capturing edge
   task automatic apply_stimulus(input logic pv, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic be, input logic bd, input logic pr, input logic fl);
      push_valid     = pv;
      inst_in        = inst;
      pc_in          = pc;
      normal_in      = pc + 32'd4;
      bp_en_in       = be;
      bp_decision_in = bd;
      pop_ready      = pr;
      flush          = fl;
      @(posedge clk);
      #1;
   endtask

   // Compare against the model state, then advance the model with the inputs for the coming edge
   always @(negedge clk) begin
      entry_t e;
      logic   accept;
      if (!rst) begin
         exp_q.delete();
         check_output("reset_out_valid", {31'd0, out_valid}, 32'd0);
         check_output("reset_count", {29'd0, count}, 32'd0);
      end else begin
         check_output("count", {29'd0, count}, exp_q.size());
         check_output("push_ready", {31'd0, push_ready}, (exp_q.size() != DEPTH) ? 32'd1 : 32'd0);
         if (exp_q.size() > 0) begin
            e = exp_q[0];
            check_output("out_valid", {31'd0, out_valid}, 32'd1);
            check_output("inst_out", inst_out, e.inst);
            check_output("pc_out", pc_out, e.pc);
            check_output("normal_out", normal_out, e.normal);
            check_output("bp_en_out", {31'd0, bp_en_out}, {31'd0, e.bp_en});
            check_output("bp_decision_out", {31'd0, bp_decision_out}, {31'd0, e.bp_dec});
         end else begin
            check_output("empty_valid", {31'd0, out_valid}, 32'd0);
            check_output("empty_inst", inst_out, 32'h0000_0013);
            check_output("empty_pc", pc_out, 32'd0);
            check_output("empty_normal", normal_out, 32'd0);
            check_output("empty_bp", {30'd0, bp_en_out, bp_decision_out}, 32'd0);
         end
         if (flush) begin
            exp_q.delete();
         end else begin
            accept = push_valid && (exp_q.size() < DEPTH);
            if (pop_ready && exp_q.size() > 0)
               void'(exp_q.pop_front());
            if (accept)
               exp_q.push_back('{inst: inst_in, pc: pc_in, normal: normal_in,
                                 bp_en: bp_en_in, bp_dec: bp_decision_in});
         end
      end
   end

   initial begin
      rst = 1'b0;
      push_valid = 0; inst_in = 0; pc_in = 0; normal_in = 0;
      bp_en_in = 0; bp_decision_in = 0; pop_ready = 0; flush = 0;
      #3;
      check_output("rst_idle_valid", {31'd0, out_valid}, 32'd0);
      check_output("rst_idle_inst", inst_out, 32'h0000_0013);
      check_output("rst_idle_count", {29'd0, count}, 32'd0);
      check_output("rst_idle_ready", {31'd0, push_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      apply_stimulus(0, 32'h0, 32'h0, 0, 0, 0, 0);

      // Two pushes without pops
      apply_stimulus(1, 32'h00A0_0093, 32'h0, 0, 0, 0, 0);
      apply_stimulus(1, 32'h0010_0113, 32'h4, 1, 1, 0, 0);
      check_output("count_two", {29'd0, count}, 32'd2);

      // Fill to DEPTH, fifth push refused
      apply_stimulus(1, 32'h0020_0193, 32'h8, 0, 0, 0, 0);
      apply_stimulus(1, 32'h0030_8263, 32'hC, 1, 0, 0, 0);
      check_output("full_ready", {31'd0, push_ready}, 32'd0);
      apply_stimulus(1, 32'h0040_0213, 32'h10, 0, 0, 0, 0);
      check_output("full_count", {29'd0, count}, 32'd4);
      apply_stimulus(0, 32'h0, 32'h0, 0, 0, 1, 0);
      check_output("pop_frees_slot", {31'd0, push_ready}, 32'd1);
      check_output("count_after_pop", {29'd0, count}, 32'd3);

      // Flush with simultaneous push and pop at count=3
      apply_stimulus(1, 32'h0050_0293, 32'h14, 1, 1, 1, 1);
      check_output("flush_count", {29'd0, count}, 32'd0);
      check_output("flush_valid", {31'd0, out_valid}, 32'd0);
      apply_stimulus(0, 32'h0, 32'h0, 0, 0, 0, 0);

      // Streaming push+pop across pointer wrap, PCs 0x0..0x24 with mixed bp bits
      apply_stimulus(1, 32'h0000_0093, 32'h0, 0, 0, 0, 0);
      apply_stimulus(1, 32'h0010_0093, 32'h4, 1, 1, 0, 0);
      for (int i = 2; i < 10; i++) begin
         apply_stimulus(1, 32'h0000_0093 | (i << 20), 32'(i * 4), i[0], i[1], 1, 0);
         check_output("stream_count", {29'd0, count}, 32'd2);
      end
      apply_stimulus(0, 32'h0, 32'h0, 0, 0, 1, 0);
      apply_stimulus(0, 32'h0, 32'h0, 0, 0, 1, 0);
      check_output("drained_valid", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset while entries are held
      apply_stimulus(1, 32'h0060_0313, 32'h40, 0, 0, 0, 0);
      apply_stimulus(1, 32'h0070_0393, 32'h44, 1, 1, 0, 0);
      push_valid = 0;
      #2 rst = 1'b0;
      #1;
      check_output("async_rst_count", {29'd0, count}, 32'd0);
      check_output("async_rst_valid", {31'd0, out_valid}, 32'd0);
      check_output("async_rst_inst", inst_out, 32'h0000_0013);
      @(posedge clk);
      #1 rst = 1'b1;

      // Operation resumes after reset
      apply_stimulus(1, 32'h0080_0413, 32'h80, 1, 0, 0, 0);
      apply_stimulus(0, 32'h0, 32'h0, 0, 0, 1, 0);
      apply_stimulus(0, 32'h0, 32'h0, 0, 0, 0, 0);
      check_output("final_count", {29'd0, count}, 32'd0);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
